bounce_box_renderer: RTL and testbench

// - Pixel stage directly downstream of VGAController: consumes hcount/vcount/de/hsync/vsync, draws a solid box over a

---
 rtl/bounce_box_renderer.sv | 208 ++++++++++++++++++++
 tb/tb_bounce_box_renderer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bounce_box_renderer.sv
// Two-stage pixel renderer: a bouncing solid box drawn over a fixed background, timing delayed to match.
// Optional build macro BOX_BORDER_EN adds a 2-pixel red border inside the box edges.
module bounce_box_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_W    = 200,
  parameter int BOX_H    = 100,
  parameter int STEP     = 2,
  parameter int BOX_X0   = 220,
  parameter int BOX_Y0   = 200
) (
  input  logic       pix_clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       de,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pause,
  output logic       hsync,
  output logic       vsync,
  output logic       sdl_de,
  output logic [9:0] sdl_x,
  output logic [9:0] sdl_y,
  output logic [7:0] sdl_r,
  output logic [7:0] sdl_g,
  output logic [7:0] sdl_b,
  output logic       frame_tick
);

  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_e;

  localparam logic [10:0] H_ACT11 = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT11 = 11'(V_ACTIVE);
  localparam logic [10:0] W11     = 11'(BOX_W);
  localparam logic [10:0] H11     = 11'(BOX_H);
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [9:0]  STEP10  = 10'(STEP);
  localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - BOX_W);
  localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - BOX_H);

  // Box position and direction state
  logic [9:0] box_x_q, box_x_d, box_y_q, box_y_d;
  dir_e       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic       frame_tick_q, frame_tick_d;

  // Stage 1 registers
  logic       s1_hsync_q, s1_vsync_q, s1_de_q, s1_inside_q;
  logic [9:0] s1_x_q, s1_y_q;
  logic       s1_inside_d;

  // Stage 2 registers
  logic       hsync_q, vsync_q, de_q;
  logic [9:0] x_q, y_q;
  logic [7:0] r_q, g_q, b_q, r_d, g_d, b_d;

  logic        tick_cond;
  logic [10:0] hc11, vc11, bx11, by11;

  assign tick_cond = (hcount == 10'd0) && ({1'b0, vcount} == V_ACT11);
  assign hc11 = {1'b0, hcount};
  assign vc11 = {1'b0, vcount};
  assign bx11 = {1'b0, box_x_q};
  assign by11 = {1'b0, box_y_q};

  // Direction FSMs: position only moves on the tick, which falls in vertical blanking.
  always_comb begin
    box_x_d      = box_x_q;
    box_y_d      = box_y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    frame_tick_d = tick_cond;
    if (tick_cond && !pause) begin
      case (dir_x_q)
        DIR_POS: begin
          if (bx11 + W11 + STEP11 >= H_ACT11) begin
            box_x_d = X_MAX;
            dir_x_d = DIR_NEG;
          end else begin
            box_x_d = box_x_q + STEP10;
          end
        end
        default: begin
          if (box_x_q <= STEP10) begin
            box_x_d = 10'd0;
            dir_x_d = DIR_POS;
          end else begin
            box_x_d = box_x_q - STEP10;
          end
        end
      endcase
      case (dir_y_q)
        DIR_POS: begin
          if (by11 + H11 + STEP11 >= V_ACT11) begin
            box_y_d = Y_MAX;
            dir_y_d = DIR_NEG;
          end else begin
            box_y_d = box_y_q + STEP10;
          end
        end
        default: begin
          if (box_y_q <= STEP10) begin
            box_y_d = 10'd0;
            dir_y_d = DIR_POS;
          end else begin
            box_y_d = box_y_q - STEP10;
          end
        end
      endcase
    end
  end

  always_comb begin
    s1_inside_d = (hc11 >= bx11) && (hc11 < bx11 + W11) &&
                  (vc11 >= by11) && (vc11 < by11 + H11);
  end

`ifdef BOX_BORDER_EN
  logic s1_border_q, s1_border_d;
  always_comb begin
    s1_border_d = s1_inside_d &&
                  ((hc11 < bx11 + 11'd2) || (hc11 + 11'd2 >= bx11 + W11) ||
                   (vc11 < by11 + 11'd2) || (vc11 + 11'd2 >= by11 + H11));
  end
  always_ff @(posedge pix_clk) begin
    if (reset) s1_border_q <= 1'b0;
    else       s1_border_q <= s1_border_d;
  end
`endif

  always_comb begin
    r_d = 8'h00;
    g_d = 8'h00;
    b_d = 8'h00;
    if (s1_de_q) begin
      if (s1_inside_q) begin
        r_d = 8'hFF;
        g_d = 8'hFF;
        b_d = 8'hFF;
`ifdef BOX_BORDER_EN
        if (s1_border_q) begin
          g_d = 8'h00;
          b_d = 8'h00;
        end
`endif
      end else begin
        r_d = 8'h11;
        g_d = 8'h33;
        b_d = 8'h77;
      end
    end
  end

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      box_x_q      <= 10'(BOX_X0);
      box_y_q      <= 10'(BOX_Y0);
      dir_x_q      <= DIR_POS;
      dir_y_q      <= DIR_POS;
      frame_tick_q <= 1'b0;
      s1_hsync_q   <= 1'b1;
      s1_vsync_q   <= 1'b1;
      s1_de_q      <= 1'b0;
      s1_x_q       <= 10'd0;
      s1_y_q       <= 10'd0;
      s1_inside_q  <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      de_q         <= 1'b0;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      r_q          <= 8'h00;
      g_q          <= 8'h00;
      b_q          <= 8'h00;
    end else begin
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      frame_tick_q <= frame_tick_d;
      s1_hsync_q   <= hsync_in;
      s1_vsync_q   <= vsync_in;
      s1_de_q      <= de;
      s1_x_q       <= hcount;
      s1_y_q       <= vcount;
      s1_inside_q  <= s1_inside_d;
      hsync_q      <= s1_hsync_q;
      vsync_q      <= s1_vsync_q;
      de_q         <= s1_de_q;
      x_q          <= s1_x_q;
      y_q          <= s1_y_q;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign sdl_de     = de_q;
  assign sdl_x      = x_q;
  assign sdl_y      = y_q;
  assign sdl_r      = r_q;
  assign sdl_g      = g_q;
  assign sdl_b      = b_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bounce_box_renderer.sv
// Directed bench for bounce_box_renderer: pixel colours, 2-cycle latency, frame ticks, bounce and pause.
module tb_bounce_box_renderer;

  logic       pix_clk = 1'b0;
  logic       reset;
  logic [9:0] hcount, vcount;
  logic       de, hsync_in, vsync_in, pause;
  logic       hsync, vsync, sdl_de, frame_tick;
  logic [9:0] sdl_x, sdl_y;
  logic [7:0] sdl_r, sdl_g, sdl_b;

  int n_checks = 0;
  int n_errors = 0;
  int pulses;

  localparam logic [23:0] BG    = 24'h113377;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;
`ifdef BOX_BORDER_EN
  localparam logic [23:0] EDGE_RGB = 24'hFF0000;
`else
  localparam logic [23:0] EDGE_RGB = 24'hFFFFFF;
`endif

  always #5 pix_clk = ~pix_clk;

  bounce_box_renderer dut (
    .pix_clk(pix_clk), .reset(reset), .hcount(hcount), .vcount(vcount), .de(de),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .hsync(hsync), .vsync(vsync), .sdl_de(sdl_de), .sdl_x(sdl_x), .sdl_y(sdl_y),
    .sdl_r(sdl_r), .sdl_g(sdl_g), .sdl_b(sdl_b), .frame_tick(frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic set_idle();
    hcount = 10'd700; vcount = 10'd0; de = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
  endtask

  task automatic step();
    @(posedge pix_clk);
    #1;
  endtask

  // Present one pixel for a cycle; on return its result is on the outputs.
  task automatic drive_px(input int h, input int v, input logic d);
    hcount = 10'(h); vcount = 10'(v); de = d;
    step();
    set_idle();
    step();
  endtask

  task automatic do_tick(output int n);
    n = 0;
    hcount = 10'd0; vcount = 10'd480; de = 1'b0;
    step();
    n += int'(frame_tick);
    set_idle();
    step();
    n += int'(frame_tick);
  endtask

  initial begin
    int acc;
    reset = 1'b1; pause = 1'b0;
    hcount = 10'd221; vcount = 10'd201; de = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    step(); step(); step();
    check("rst_hsync", {31'd0, hsync}, 32'd1);
    check("rst_vsync", {31'd0, vsync}, 32'd1);
    check("rst_de", {31'd0, sdl_de}, 32'd0);
    check("rst_x", {22'd0, sdl_x}, 32'd0);
    check("rst_y", {22'd0, sdl_y}, 32'd0);
    check("rst_rgb", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, BLACK});
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    reset = 1'b0;
    set_idle();
    step();

    drive_px(221, 201, 1'b1);
    check("px221_x", {22'd0, sdl_x}, 32'd221);
    check("px221_y", {22'd0, sdl_y}, 32'd201);
    check("px221_de", {31'd0, sdl_de}, 32'd1);
    check("px221_rgb", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, EDGE_RGB});
    drive_px(100, 100, 1'b1);
    check("px100_rgb", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, BG});
    drive_px(100, 100, 1'b0);
    check("px100_de0_rgb", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, BLACK});
    check("px100_de0_de", {31'd0, sdl_de}, 32'd0);
    drive_px(219, 250, 1'b1);
    check("left_out", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, BG});
    drive_px(419, 299, 1'b1);
    check("br_in", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, EDGE_RGB});
    drive_px(420, 250, 1'b1);
    check("right_out", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, BG});
    drive_px(320, 300, 1'b1);
    check("bottom_out", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, BG});

    // Sync pulse must appear exactly two cycles later
    hsync_in = 1'b0; vsync_in = 1'b0;
    step();
    check("sync_d1_h", {31'd0, hsync}, 32'd1);
    hsync_in = 1'b1; vsync_in = 1'b1;
    step();
    check("sync_d2_h", {31'd0, hsync}, 32'd0);
    check("sync_d2_v", {31'd0, vsync}, 32'd0);
    step();
    check("sync_d3_h", {31'd0, hsync}, 32'd1);

    do_tick(pulses);
    check("tick1_pulses", pulses, 32'd1);
    check("tick1_x", {22'd0, dut.box_x_q}, 32'd222);
    check("tick1_y", {22'd0, dut.box_y_q}, 32'd202);
    drive_px(220, 200, 1'b1);
    check("old_corner_bg", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, BG});
    drive_px(222, 202, 1'b1);
    check("new_corner", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, EDGE_RGB});

    pause = 1'b1;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      do_tick(pulses);
      acc += pulses;
    end
    pause = 1'b0;
    check("pause_pulses", acc, 32'd3);
    check("pause_x", {22'd0, dut.box_x_q}, 32'd222);
    check("pause_y", {22'd0, dut.box_y_q}, 32'd202);

    // 108 more moving ticks brings x to 438; y bounced at 380 on tick 90
    for (int i = 0; i < 108; i++) do_tick(pulses);
    check("t109_x", {22'd0, dut.box_x_q}, 32'd438);
    check("t109_y", {22'd0, dut.box_y_q}, 32'd342);
    do_tick(pulses);
    check("t110_x", {22'd0, dut.box_x_q}, 32'd440);
    check("t110_y", {22'd0, dut.box_y_q}, 32'd340);
    drive_px(639, 340, 1'b1);
    check("t110_right_edge", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, EDGE_RGB});
    drive_px(439, 340, 1'b1);
    check("t110_left_out", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, BG});
    do_tick(pulses);
    check("t111_x", {22'd0, dut.box_x_q}, 32'd438);
    check("t111_y", {22'd0, dut.box_y_q}, 32'd338);

    // Reset in the middle of active video
    hcount = 10'd300; vcount = 10'd300; de = 1'b1;
    step();
    reset = 1'b1;
    step();
    check("mid_rst_de", {31'd0, sdl_de}, 32'd0);
    check("mid_rst_rgb", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, BLACK});
    check("mid_rst_x", {22'd0, dut.box_x_q}, 32'd220);
    reset = 1'b0;
    set_idle();
    step();
    do_tick(pulses);
    check("post_rst_x", {22'd0, dut.box_x_q}, 32'd222);
    check("post_rst_y", {22'd0, dut.box_y_q}, 32'd202);

    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
`ifdef BOX_BORDER_EN
    drive_px(221, 250, 1'b1);
    check("border_px", {8'd0, sdl_r, sdl_g, sdl_b}, 32'h00FF0000);
`endif
    drive_px(320, 250, 1'b1);
    check("interior_px", {8'd0, sdl_r, sdl_g, sdl_b}, {8'd0, WHITE});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
